// File: rtl/ysyx_220053_mem_arb.sv
// ysyx_220053_mem_arb: shares one downstream memory port between the
// instruction fetch unit (read-only) and the load/store unit. It runs one
// transaction at a time: grant, issue, wait for the response, then return
// the response to the requester that owns the transaction.
// Optional feature: define ARB_RR_EN for round-robin arbitration. When it
// is undefined, LSU has fixed priority over IFU.
module ysyx_220053_mem_arb #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_req_addr,
  output logic            ifu_resp_valid,
  output logic [DW-1:0]   ifu_resp_data,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic            lsu_req_wen,
  input  logic [DW-1:0]   lsu_req_wdata,
  input  logic [DW/8-1:0] lsu_req_wmask,
  output logic            lsu_resp_valid,
  output logic [DW-1:0]   lsu_resp_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_req_addr,
  output logic            mem_req_wen,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_resp_data,
  output logic            owner
);

  localparam int MW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            prio_lsu;
  logic            grant_lsu;
  logic            grant_ifu;
  logic            accept;

`ifdef ARB_RR_EN
  logic            last_q, last_d;

  // Under contention the requester that did not win last time goes first.
  assign prio_lsu = ~last_q;
`else
  assign prio_lsu = 1'b1;
`endif

  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | prio_lsu);
  assign grant_ifu = ifu_req_valid & ~grant_lsu;
  assign accept    = (state_q == S_IDLE) & (grant_lsu | grant_ifu);

  // Ready is held low while reset is asserted so nothing looks accepted
  // on a cycle whose state update is discarded.
  assign ifu_req_ready  = accept & grant_ifu & ~rst;
  assign lsu_req_ready  = accept & grant_lsu & ~rst;

  assign mem_req_valid  = (state_q == S_ISSUE);
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;

  assign ifu_resp_valid = (state_q == S_RESP) & ~owner_q;
  assign lsu_resp_valid = (state_q == S_RESP) &  owner_q;
  assign ifu_resp_data  = rdata_q;
  assign lsu_resp_data  = rdata_q;
  assign owner          = owner_q;

  // Next-state logic: latch the granted request, track the handshake, and
  // capture read data only while waiting for the response.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          owner_d = grant_lsu;
          if (grant_lsu) begin
            addr_d  = lsu_req_addr;
            wen_d   = lsu_req_wen;
            wdata_d = lsu_req_wdata;
            // A load carries no byte enables downstream.
            wmask_d = lsu_req_wen ? lsu_req_wmask : '0;
          end else begin
            addr_d  = ifu_req_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_d = S_RESP;
          rdata_d = mem_resp_data;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef ARB_RR_EN
  // Remember who won the most recent accept.
  always_comb begin
    last_d = last_q;
    if (accept) last_d = grant_lsu;
  end

  // Last-grant register; reset value points at IFU so LSU wins first.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
  end
`endif

  // State and latched request/response registers; reset clears every
  // field so all outputs read zero and any in-flight request is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ysyx_220053_mem_arb.sv
// Bench for ysyx_220053_mem_arb: directed vectors, a memory responder with
// configurable stall/response gap, and a scoreboard monitor that checks
// every response strobe against the queue of expected responses.
module tb_ysyx_220053_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [63:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic [63:0] ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_resp_valid;
  logic [63:0] lsu_resp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        owner;

  always #5 clk = ~clk;

  ysyx_220053_mem_arb #(.AW(64), .DW(64)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .owner(owner)
  );

  typedef struct {
    bit          lsu;
    bit          chk_data;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mem_data_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Responder knobs, written only by the stimulus process.
  int stall_req = 0;
  int resp_gap  = 0;
  bit spur      = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: drives at the falling edge, DUT samples at the rising edge.
  initial begin : responder
    bit pend = 1'b0;
    bit in_issue = 1'b0;
    int cnt = 0;
    int gap_cnt = 0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (pend) begin
        if (gap_cnt > 0) gap_cnt--;
        else begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = (mem_data_q.size() > 0) ? mem_data_q.pop_front() : 64'h0;
          pend = 1'b0;
        end
      end else begin
        if (spur) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        end
        if (mem_req_valid === 1'b1) begin
          if (!in_issue) begin
            in_issue = 1'b1;
            cnt = stall_req;
          end
          if (cnt > 0) cnt--;
          else begin
            mem_req_ready = 1'b1;
            in_issue = 1'b0;
            pend = 1'b1;
            gap_cnt = resp_gap;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every response strobe must match the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifu_resp_valid === 1'b1 || lsu_resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_resp: got ifu=%b lsu=%b, expected no strobe",
                   ifu_resp_valid, lsu_resp_valid);
        end else begin
          e = exp_q.pop_front();
          chk("resp_route", {62'd0, ifu_resp_valid, lsu_resp_valid},
              e.lsu ? 64'd1 : 64'd2);
          if (e.chk_data)
            chk("resp_data", e.lsu ? lsu_resp_data : ifu_resp_data, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_ready(input bit is_lsu);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (is_lsu ? lsu_req_ready : ifu_req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no ready, expected ready for %s",
               is_lsu ? "lsu" : "ifu");
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk({nm, "_drained"}, exp_q.size(), 0);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, "_ifu_ready"}, ifu_req_ready, 0);
    chk({p, "_lsu_ready"}, lsu_req_ready, 0);
    chk({p, "_ifu_rvalid"}, ifu_resp_valid, 0);
    chk({p, "_lsu_rvalid"}, lsu_resp_valid, 0);
    chk({p, "_ifu_rdata"}, ifu_resp_data, 0);
    chk({p, "_lsu_rdata"}, lsu_resp_data, 0);
    chk({p, "_mem_valid"}, mem_req_valid, 0);
    chk({p, "_mem_addr"}, mem_req_addr, 0);
    chk({p, "_mem_wen"}, mem_req_wen, 0);
    chk({p, "_mem_wdata"}, mem_req_wdata, 0);
    chk({p, "_mem_wmask"}, mem_req_wmask, 0);
    chk({p, "_owner"}, owner, 0);
  endtask

  initial begin : stimulus
    bit          exp_order[4];
    logic [63:0] cdata[4];
    int          k, cyc, n, nis;

`ifdef ARB_RR_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
    cdata = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
              64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004};

    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_req_addr = '0;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0;   lsu_req_wmask = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk); #1;

    // Contention straight after reset: three accepts with both valid,
    // then LSU drops and IFU takes the fourth.
    for (int i = 0; i < 4; i++) mem_data_q.push_back(cdata[i]);
    ifu_req_addr = 64'h8000_0040;
    lsu_req_addr = 64'h8000_3000; lsu_req_wen = 1'b0; lsu_req_wmask = 8'h00;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 100) begin
      #1;
      if (ifu_req_ready || lsu_req_ready) begin
        chk("cont_grant", {62'd0, ifu_req_ready, lsu_req_ready},
            exp_order[k] ? 64'd1 : 64'd2);
        exp_q.push_back('{exp_order[k], 1'b1, cdata[k]});
        k++;
        @(negedge clk);
        if (k == 3) lsu_req_valid = 1'b0;
        if (k == 4) ifu_req_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    chk("cont_accepts", k, 4);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    drain("cont");

    // Single fetch: accept at T, response strobe at T+3, data then held.
    mem_data_q.push_back(64'h0000_0413);
    ifu_req_addr = 64'h8000_0000;
    ifu_req_valid = 1'b1;
    wait_ready(1'b0);
    exp_q.push_back('{1'b0, 1'b1, 64'h0000_0413});
    @(negedge clk);
    ifu_req_valid = 1'b0;
    #1;
    chk("fetch_issue_valid", mem_req_valid, 1);
    chk("fetch_issue_addr", mem_req_addr, 64'h8000_0000);
    chk("fetch_issue_wen", mem_req_wen, 0);
    chk("fetch_owner", owner, 0);
    n = 1;
    while (ifu_resp_valid !== 1'b1 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk("fetch_latency", n, 3);
    chk("fetch_lsu_quiet", lsu_resp_valid, 0);
    @(negedge clk); #1;
    chk("fetch_strobe_1cyc", ifu_resp_valid, 0);
    chk("fetch_data_hold", ifu_resp_data, 64'h0000_0413);
    drain("fetch");

    // Store with three stall cycles: fields stable for all four ISSUE cycles.
    stall_req = 3;
    mem_data_q.push_back(64'h0);
    lsu_req_addr = 64'h8000_1000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 64'hDEAD_BEEF; lsu_req_wmask = 8'h0F;
    lsu_req_valid = 1'b1;
    wait_ready(1'b1);
    exp_q.push_back('{1'b1, 1'b0, 64'h0});
    @(negedge clk);
    lsu_req_valid = 1'b0;
    nis = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mem_req_valid === 1'b1) begin
        nis++;
        chk("store_addr", mem_req_addr, 64'h8000_1000);
        chk("store_wen", mem_req_wen, 1);
        chk("store_wdata", mem_req_wdata, 64'h0000_0000_DEAD_BEEF);
        chk("store_wmask", mem_req_wmask, 8'h0F);
      end else if (nis > 0) begin
        break;
      end
      @(negedge clk);
    end
    chk("store_issue_cycles", nis, 4);
    chk("store_fields_hold", mem_req_addr, 64'h8000_1000);
    stall_req = 0;
    drain("store");

    // Spurious responses in IDLE and ISSUE must be ignored.
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("spur_idle_noissue", mem_req_valid, 0);
    end
    stall_req = 1;
    mem_data_q.push_back(64'h0010_0093);
    ifu_req_addr = 64'h8000_0080;
    ifu_req_valid = 1'b1;
    wait_ready(1'b0);
    exp_q.push_back('{1'b0, 1'b1, 64'h0010_0093});
    @(negedge clk);
    ifu_req_valid = 1'b0;
    drain("spur");
    spur = 1'b0;
    stall_req = 0;

    // Reset while waiting: everything clears, the late response is ignored.
    resp_gap = 3;
    mem_data_q.push_back(64'h5555_5555_5555_5555);
    ifu_req_addr = 64'h8000_0100;
    ifu_req_valid = 1'b1;
    wait_ready(1'b0);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    #1;
    chk("midrst_issue", mem_req_valid, 1);
    @(negedge clk); #1;
    chk("midrst_wait", mem_req_valid, 0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk_all_zero("midrst");
    rst = 1'b0;
    resp_gap = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("midrst_stays_idle", mem_req_valid, 0);
    end
    mem_data_q.push_back(64'h00A0_0093);
    ifu_req_addr = 64'h8000_0200;
    ifu_req_valid = 1'b1;
    wait_ready(1'b0);
    exp_q.push_back('{1'b0, 1'b1, 64'h00A0_0093});
    @(negedge clk);
    ifu_req_valid = 1'b0;
    #1;
    chk("post_rst_addr", mem_req_addr, 64'h8000_0200);
    drain("post_rst");

    // Load with a full mask: mask and wen go downstream as zero.
    mem_data_q.push_back(64'hCAFE_F00D_1234_5678);
    lsu_req_addr = 64'h8000_2000; lsu_req_wen = 1'b0;
    lsu_req_wdata = 64'h1111; lsu_req_wmask = 8'hFF;
    lsu_req_valid = 1'b1;
    wait_ready(1'b1);
    exp_q.push_back('{1'b1, 1'b1, 64'hCAFE_F00D_1234_5678});
    @(negedge clk);
    lsu_req_valid = 1'b0;
    #1;
    chk("load_wmask", mem_req_wmask, 8'h00);
    chk("load_wen", mem_req_wen, 0);
    chk("load_addr", mem_req_addr, 64'h8000_2000);
    chk("load_owner", owner, 1);
    drain("load");

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
